// File: rtl/alarm_zone_ctrl.sv
// alarm_zone_ctrl: multi-zone alarm FSM with entry delay, timed hold, arming fault and zone latch
module alarm_zone_ctrl #(
  parameter int NUM_ZONES   = 4,
  parameter int ENTRY_DELAY = 8,
  parameter int ALARM_HOLD  = 16,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic [NUM_ZONES-1:0] zone_mask,
  input  logic [NUM_ZONES-1:0] instant_mask,
  input  logic [NUM_ZONES-1:0] sensor,
  output logic [1:0]           state,
  output logic [1:0]           next_state,
  output logic                 alarm,
  output logic                 arm_fault,
  output logic [NUM_ZONES-1:0] zone_latched,
  output logic [CNT_W-1:0]     delay_cnt
);
  typedef enum logic [1:0] {OFF = 2'b00, ARMED = 2'b01, TRIG = 2'b10, ALARM_ON = 2'b11} state_t;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_ZONES-1:0] latched_q, latched_d, hit, inst;
  logic                 fault_q, fault_d;
  // next state, countdown, fault pulse and zone latch; everything holds when ena is low
  always_comb begin
    hit = sensor & zone_mask;
    inst = hit & instant_mask;
    state_d = state_q;
    cnt_d = cnt_q;
    latched_d = latched_q;
    fault_d = 1'b0;
    if (ena) begin
      if (disarm) state_d = OFF;
      else case (state_q)
        OFF: begin
          fault_d = arm & (|hit);
          state_d = arm & ~(|hit) ? ARMED : OFF;
        end
        ARMED: begin
          state_d = |inst ? ALARM_ON : |hit ? TRIG : ARMED;
          cnt_d = |inst ? CNT_W'(ALARM_HOLD - 1) : CNT_W'(ENTRY_DELAY - 1);
        end
        TRIG: begin
          state_d = (|inst) || cnt_q == '0 ? ALARM_ON : TRIG;
          cnt_d = (|inst) || cnt_q == '0 ? CNT_W'(ALARM_HOLD - 1) : cnt_q - 1'b1;
        end
        ALARM_ON: begin
          state_d = cnt_q == '0 ? ARMED : ALARM_ON;
          cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
        end
      endcase
      if (!state_d[1]) cnt_d = '0;
      latched_d = state_d == OFF ? '0 : state_q != OFF ? latched_q | hit : latched_q;
    end
  end
  // register update with synchronous reset taking priority over ena
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q <= '0;
      latched_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      latched_q <= latched_d;
      fault_q <= fault_d;
    end
  end
  assign state = state_q;
  assign next_state = state_d;
  assign alarm = state_q == ALARM_ON;
  assign arm_fault = fault_q;
  assign zone_latched = latched_q;
  assign delay_cnt = cnt_q;
endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// tb_alarm_zone_ctrl: directed scenarios plus random traffic against a deadline-based reference model
module tb_alarm_zone_ctrl;
  localparam int NZ = 4, ED = 8, AH = 16, CW = 8;
  logic clk = 1'b0, rst, ena, arm, disarm;
  logic [NZ-1:0] zone_mask, instant_mask, sensor;
  logic [1:0] state, next_state;
  logic alarm, arm_fault;
  logic [NZ-1:0] zone_latched;
  logic [CW-1:0] delay_cnt;
  int errors = 0, checks = 0;
  string tn = "init";
  // model: phase 0..3, t counts enabled edges, t_end is the timestamp at which the current timed phase expires
  int ph = 0, t = 0, t_end = 0, nph, nend;
  logic [NZ-1:0] lat = '0, nlat;
  bit flt = 0, nflt;

  alarm_zone_ctrl #(.NUM_ZONES(NZ), .ENTRY_DELAY(ED), .ALARM_HOLD(AH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .arm(arm), .disarm(disarm),
    .zone_mask(zone_mask), .instant_mask(instant_mask), .sensor(sensor),
    .state(state), .next_state(next_state), .alarm(alarm), .arm_fault(arm_fault),
    .zone_latched(zone_latched), .delay_cnt(delay_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%0d expected=%0d", tn, tag, got, exp);
    end
  endtask

  task automatic model_next();
    logic [NZ-1:0] h, in;
    h = sensor & zone_mask;
    in = h & instant_mask;
    nph = ph; nend = t_end; nlat = lat; nflt = 0;
    if (rst) begin
      nph = 0; nlat = '0;
    end else if (ena) begin
      if (disarm) nph = 0;
      else if (ph == 0) begin
        if (arm && h != 0) nflt = 1;
        else if (arm) nph = 1;
      end else if ((ph == 1 && in != 0) || (ph == 2 && (in != 0 || t == t_end))) begin
        nph = 3; nend = t + AH;
      end else if (ph == 1 && h != 0) begin
        nph = 2; nend = t + ED;
      end else if (ph == 3 && t == t_end) nph = 1;
      if (nph == 0) nlat = '0;
      else if (ph != 0) nlat = lat | h;
    end
  endtask

  task automatic step(input logic r, e, a, d, input logic [NZ-1:0] zm, im, s);
    @(negedge clk);
    rst = r; ena = e; arm = a; disarm = d; zone_mask = zm; instant_mask = im; sensor = s;
    #1;
    model_next();
    if (!r) chk("next_state", next_state, nph);
    @(posedge clk);
    #1;
    if (!r && e) t++;
    ph = nph; t_end = nend; lat = nlat; flt = nflt;
    chk("state", state, ph);
    chk("alarm", alarm, ph == 3);
    chk("arm_fault", arm_fault, flt);
    chk("zone_latched", zone_latched, lat);
    chk("delay_cnt", delay_cnt, ph >= 2 ? t_end - t : 0);
  endtask

  initial begin
    tn = "T1";
    step(1, 1, 0, 0, 4'hF, 0, 0);
    step(1, 1, 0, 0, 4'hF, 0, 0);
    chk("rst_state", state, 0);
    step(0, 1, 1, 0, 4'hF, 0, 0);
    chk("armed", state, 1);
    tn = "T2";
    step(0, 1, 0, 0, 4'hF, 0, 4'b0100);
    chk("cnt_start", delay_cnt, 7);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 4'hF, 0, 0);
    chk("cnt_end", delay_cnt, 0);
    chk("still_trig", state, 2);
    step(0, 1, 0, 0, 4'hF, 0, 0);
    chk("alarm_on", state, 3);
    chk("latch", zone_latched, 4'b0100);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 4'hF, 0, 0);
    chk("rearm", state, 1);
    chk("latch_kept", zone_latched, 4'b0100);
    tn = "T3";
    step(0, 1, 0, 1, 4'hF, 0, 0);
    step(0, 1, 1, 0, 4'hF, 0, 0);
    step(0, 1, 0, 0, 4'hF, 4'b0001, 4'b0001);
    chk("instant", state, 3);
    chk("hold_cnt", delay_cnt, 15);
    step(0, 1, 0, 1, 4'hF, 0, 0);
    step(0, 1, 1, 0, 4'hF, 0, 0);
    tn = "T4";
    step(0, 1, 0, 0, 4'hF, 0, 4'b0010);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 4'hF, 0, 0);
    chk("cnt3", delay_cnt, 3);
    step(0, 1, 0, 1, 4'hF, 0, 0);
    chk("disarmed", state, 0);
    chk("latch_clr", zone_latched, 0);
    step(0, 1, 1, 1, 4'hF, 0, 0);
    chk("arm_disarm", state, 0);
    tn = "T5";
    step(0, 1, 1, 0, 4'hF, 0, 4'b0010);
    chk("fault", arm_fault, 1);
    step(0, 1, 0, 0, 4'hF, 0, 4'b0010);
    chk("fault_gone", arm_fault, 0);
    step(0, 1, 1, 0, 4'b1101, 0, 4'b0010);
    chk("masked_arm", state, 1);
    tn = "T6";
    step(0, 1, 0, 0, 4'hF, 4'b0001, 4'b0001);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 4'hF, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 4'hF, 4'hF, 4'hF);
    chk("frozen", delay_cnt, 9);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 4'hF, 0, 0);
    chk("last_hold", state, 3);
    step(0, 1, 0, 0, 4'hF, 0, 0);
    chk("autorearm", state, 1);
    chk("latch_kept", zone_latched, 4'b0001);
    tn = "RSTMID";
    step(0, 1, 0, 0, 4'hF, 0, 4'b1000);
    step(1, 1, 0, 0, 4'hF, 0, 0);
    chk("rst_off", state, 0);
    tn = "RAND";
    for (int i = 0; i < 1500; i++)
      step($urandom_range(63) == 0, $urandom_range(7) != 0, $urandom_range(3) == 0,
           $urandom_range(15) == 0, NZ'($urandom), $urandom_range(1) ? NZ'($urandom) : '0,
           NZ'($urandom & $urandom & $urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
